tone_sequencer: RTL and testbench

- Steps through a small programmable table of (period, duration) entries.
- Drives period_out into the downstream period counter that generates a tone/PWM frequency.
- Holds each period for a programmed number of coarse time ticks.
- Supports one-shot or looped playback, immediate stop, and status/pulse outputs for the control FSM and display logic.

---
 rtl/tone_sequencer.sv | 258 +++++++++++++++++++++++++
 tb/tb_tone_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// tone_sequencer: plays a programmable table of (period, duration) steps.
// Each step drives period_out for duration * TICK_PERIOD clock cycles,
// preceded by one LOAD cycle in which the table entry is fetched.
// Playback is one-shot or looped. It can be stopped at any time, and
// status/pulse outputs are provided for the control and display logic.

module tone_sequencer #(
  parameter int NUM_STEPS    = 16,
  parameter int PERIOD_WIDTH = 32,
  parameter int DUR_WIDTH    = 16,
  parameter int TICK_PERIOD  = 100000
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           wr_en_in,
  input  logic [$clog2(NUM_STEPS)-1:0]   wr_addr_in,
  input  logic [PERIOD_WIDTH-1:0]        wr_period_in,
  input  logic [DUR_WIDTH-1:0]           wr_dur_in,
  input  logic [$clog2(NUM_STEPS):0]     len_in,
  input  logic                           loop_in,
  input  logic                           start_in,
  input  logic                           stop_in,
  output logic [PERIOD_WIDTH-1:0]        period_out,
  output logic                           active_out,
  output logic                           busy_out,
  output logic [$clog2(NUM_STEPS)-1:0]   step_out,
  output logic                           step_pulse_out,
  output logic                           done_out
);

  localparam int SW = $clog2(NUM_STEPS);
  localparam int LW = SW + 1;
  localparam int TW = $clog2(TICK_PERIOD);
  localparam int EW = PERIOD_WIDTH + DUR_WIDTH;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_PERIOD - 1);
  localparam logic [LW-1:0] LEN_MAX   = LW'(NUM_STEPS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Sequencer state and datapath registers
  state_t                 state_r;
  logic [SW-1:0]          step_r;
  logic [LW-1:0]          len_r;
  logic                   loop_r;
  logic [DUR_WIDTH-1:0]   rem_r;
  logic [TW-1:0]          tick_r;

  // Registered outputs
  logic [PERIOD_WIDTH-1:0] period_r;
  logic                    active_r;
  logic                    busy_r;
  logic                    pulse_r;
  logic                    done_r;

  // Table storage and its registered read port
  logic [EW-1:0]          table_mem [NUM_STEPS];
  logic [EW-1:0]          rd_data_r;

  // Next-state / next-value signals
  state_t                 state_s;
  logic [SW-1:0]          step_s;
  logic [LW-1:0]          len_s;
  logic                   loop_s;
  logic [DUR_WIDTH-1:0]   rem_s;
  logic [TW-1:0]          tick_s;
  logic                   end_step_s;
  logic [PERIOD_WIDTH-1:0] period_s;
  logic                   active_s;
  logic                   pulse_s;
  logic                   done_s;

  // Derived helpers
  logic [LW-1:0]           len_clamp_s;
  logic [LW-1:0]           step_inc_s;
  logic                    more_steps_s;
  logic [PERIOD_WIDTH-1:0] rd_period_s;
  logic [DUR_WIDTH-1:0]    rd_dur_s;

  assign len_clamp_s  = (len_in > LEN_MAX) ? LEN_MAX : len_in;
  assign step_inc_s   = {1'b0, step_r} + LW'(1);
  assign more_steps_s = (step_inc_s < len_r);
  assign rd_period_s  = rd_data_r[EW-1:DUR_WIDTH];
  assign rd_dur_s     = rd_data_r[DUR_WIDTH-1:0];

  // Table write port, plus a read of the step that will be current next
  // cycle, so the entry is already on rd_data_r during LOAD. A write to
  // the same address at the same edge returns the old contents.
  always_ff @(posedge clk_in) begin
    if (wr_en_in) begin
      table_mem[wr_addr_in] <= {wr_period_in, wr_dur_in};
    end
    rd_data_r <= table_mem[step_s];
  end

  // State register together with step index, latched config and counters
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r <= ST_IDLE;
      step_r  <= '0;
      len_r   <= '0;
      loop_r  <= 1'b0;
      rem_r   <= '0;
      tick_r  <= '0;
    end else begin
      state_r <= state_s;
      step_r  <= step_s;
      len_r   <= len_s;
      loop_r  <= loop_s;
      rem_r   <= rem_s;
      tick_r  <= tick_s;
    end
  end

  // Next-state logic: stop has priority over start, then normal sequencing
  always_comb begin
    state_s    = state_r;
    step_s     = step_r;
    len_s      = len_r;
    loop_s     = loop_r;
    rem_s      = rem_r;
    tick_s     = tick_r;
    end_step_s = 1'b0;

    if ((state_r != ST_IDLE) && stop_in) begin
      state_s = ST_IDLE;
      step_s  = '0;
      tick_s  = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          step_s = '0;
          if (start_in && !stop_in) begin
            len_s  = len_clamp_s;
            loop_s = loop_in;
            if (len_clamp_s == '0) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_LOAD;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (rd_dur_s == '0) begin
            end_step_s = 1'b1;
          end else begin
            state_s = ST_PLAY;
            rem_s   = rd_dur_s;
            tick_s  = '0;
          end
        end
        ST_PLAY: begin
          if (tick_r == TICK_LAST) begin
            tick_s = '0;
            if (rem_r == DUR_WIDTH'(1)) begin
              end_step_s = 1'b1;
            end else begin
              rem_s = rem_r - DUR_WIDTH'(1);
            end
          end else begin
            tick_s = tick_r + TW'(1);
          end
        end
        ST_DONE: begin
          state_s = ST_IDLE;
          step_s  = '0;
        end
        default: begin
          state_s = ST_IDLE;
          step_s  = '0;
        end
      endcase

      // End of step: advance, wrap when looping, or finish
      if (end_step_s) begin
        if (more_steps_s) begin
          step_s  = step_r + SW'(1);
          state_s = ST_LOAD;
        end else if (loop_r) begin
          step_s  = '0;
          state_s = ST_LOAD;
        end else begin
          state_s = ST_DONE;
        end
      end else begin
        step_s = step_s;
      end
    end
  end

  // Output logic: next values of the registered outputs, from the next state
  always_comb begin
    period_s = period_r;
    active_s = active_r;
    pulse_s  = 1'b0;
    done_s   = 1'b0;
    case (state_s)
      ST_IDLE: begin
        period_s = '0;
        active_s = 1'b0;
      end
      ST_LOAD: begin
        period_s = period_r;
        active_s = active_r;
      end
      ST_PLAY: begin
        if (state_r == ST_LOAD) begin
          period_s = rd_period_s;
          active_s = (rd_period_s != '0);
          pulse_s  = 1'b1;
        end else begin
          period_s = period_r;
          active_s = active_r;
        end
      end
      ST_DONE: begin
        period_s = '0;
        active_s = 1'b0;
        done_s   = 1'b1;
      end
      default: begin
        period_s = '0;
        active_s = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      period_r <= '0;
      active_r <= 1'b0;
      busy_r   <= 1'b0;
      pulse_r  <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      period_r <= period_s;
      active_r <= active_s;
      busy_r   <= (state_s != ST_IDLE);
      pulse_r  <= pulse_s;
      done_r   <= done_s;
    end
  end

  assign period_out     = period_r;
  assign active_out     = active_r;
  assign busy_out       = busy_r;
  assign step_out       = step_r;
  assign step_pulse_out = pulse_r;
  assign done_out       = done_r;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed testbench for tone_sequencer with TICK_PERIOD = 4.

module tb_tone_sequencer;

  localparam int TP = 4;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        wr_en_in;
  logic [3:0]  wr_addr_in;
  logic [31:0] wr_period_in;
  logic [15:0] wr_dur_in;
  logic [4:0]  len_in;
  logic        loop_in;
  logic        start_in;
  logic        stop_in;
  logic [31:0] period_out;
  logic        active_out;
  logic        busy_out;
  logic [3:0]  step_out;
  logic        step_pulse_out;
  logic        done_out;

  int n_checks = 0;
  int n_fail   = 0;

  tone_sequencer #(
    .NUM_STEPS(16), .PERIOD_WIDTH(32), .DUR_WIDTH(16), .TICK_PERIOD(TP)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in),
    .wr_period_in(wr_period_in), .wr_dur_in(wr_dur_in), .len_in(len_in),
    .loop_in(loop_in), .start_in(start_in), .stop_in(stop_in),
    .period_out(period_out), .active_out(active_out), .busy_out(busy_out),
    .step_out(step_out), .step_pulse_out(step_pulse_out), .done_out(done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input int a, input int p, input int d);
    wr_en_in = 1'b1; wr_addr_in = 4'(a); wr_period_in = 32'(p); wr_dur_in = 16'(d);
    cyc();
    wr_en_in = 1'b0;
  endtask

  task automatic start_seq(input int len, input bit lp);
    len_in = 5'(len); loop_in = lp; start_in = 1'b1;
    cyc();
    start_in = 1'b0;
  endtask

  // Called while in LOAD for step s; returns at the cycle after the last PLAY cycle
  task automatic play_step(input int p, input int d, input int s, input int prev, input bit inject);
    chk("load_step", 32'(step_out), 32'(s));
    chk("load_hold", period_out, 32'(prev));
    chk("load_pulse", 32'(step_pulse_out), 32'd0);
    chk("load_busy", 32'(busy_out), 32'd1);
    cyc();
    for (int i = 0; i < d * TP; i++) begin
      chk("play_period", period_out, 32'(p));
      chk("play_active", 32'(active_out), 32'(p != 0));
      chk("play_pulse", 32'(step_pulse_out), 32'(i == 0));
      chk("play_step", 32'(step_out), 32'(s));
      chk("play_done", 32'(done_out), 32'd0);
      if (inject && i == 2) begin
        start_in = 1'b1; wr_en_in = 1'b1; wr_addr_in = 4'd2;
        wr_period_in = 32'd300; wr_dur_in = 16'd2;
      end else if (inject && i == 3) begin
        start_in = 1'b0; wr_en_in = 1'b0;
      end
      cyc();
    end
  endtask

  task automatic check_done();
    chk("done_pulse", 32'(done_out), 32'd1);
    chk("done_period", period_out, 32'd0);
    chk("done_active", 32'(active_out), 32'd0);
    chk("done_busy", 32'(busy_out), 32'd1);
    cyc();
    chk("idle_busy", 32'(busy_out), 32'd0);
    chk("idle_done", 32'(done_out), 32'd0);
    chk("idle_period", period_out, 32'd0);
  endtask

  initial begin
    rst_in = 1'b0; wr_en_in = 1'b0; wr_addr_in = 4'd0; wr_period_in = 32'd0; wr_dur_in = 16'd0;
    len_in = 5'd0; loop_in = 1'b0; start_in = 1'b0; stop_in = 1'b0;
    #2 rst_in = 1'b1;
    #1;
    chk("rst_period", period_out, 32'd0);
    chk("rst_active", 32'(active_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_step", 32'(step_out), 32'd0);
    chk("rst_pulse", 32'(step_pulse_out), 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);
    cyc(); cyc();
    rst_in = 1'b0;

    wr(0, 100, 2); wr(1, 0, 1); wr(2, 250, 3);

    // stop and start together in IDLE: stop wins
    stop_in = 1'b1; start_in = 1'b1; len_in = 5'd3;
    cyc();
    stop_in = 1'b0; start_in = 1'b0;
    chk("stopstart_busy", 32'(busy_out), 32'd0);
    chk("stopstart_done", 32'(done_out), 32'd0);

    // One-shot playback
    start_seq(3, 1'b0);
    play_step(100, 2, 0, 0, 1'b0);
    play_step(0, 1, 1, 100, 1'b0);
    play_step(250, 3, 2, 0, 1'b0);
    check_done();

    // Looped playback for 3 loops, then stop
    start_seq(3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      play_step(100, 2, 0, (k == 0) ? 0 : 250, 1'b0);
      play_step(0, 1, 1, 100, 1'b0);
      play_step(250, 3, 2, 0, 1'b0);
    end
    chk("loop_wrap_step", 32'(step_out), 32'd0);
    cyc();
    chk("loop_again_period", period_out, 32'd100);
    stop_in = 1'b1;
    cyc();
    stop_in = 1'b0;
    chk("stop_period", period_out, 32'd0);
    chk("stop_busy", 32'(busy_out), 32'd0);
    chk("stop_active", 32'(active_out), 32'd0);
    chk("stop_done", 32'(done_out), 32'd0);

    // Zero-duration step is skipped
    wr(1, 0, 0);
    start_seq(3, 1'b0);
    play_step(100, 2, 0, 0, 1'b0);
    chk("skip_step", 32'(step_out), 32'd1);
    chk("skip_pulse", 32'(step_pulse_out), 32'd0);
    chk("skip_hold", period_out, 32'd100);
    cyc();
    play_step(250, 3, 2, 100, 1'b0);
    check_done();

    // len_in = 0
    start_seq(0, 1'b0);
    check_done();

    // len_in = 20 clamps to 16
    for (int i = 0; i < 16; i++) wr(i, 1000 + i, 1);
    start_seq(20, 1'b0);
    for (int i = 0; i < 16; i++) play_step(1000 + i, 1, i, (i == 0) ? 0 : 999 + i, 1'b0);
    check_done();

    // start mid-PLAY ignored; write to step 2 during step 0 takes effect
    wr(0, 100, 2); wr(1, 0, 1); wr(2, 250, 3);
    start_seq(3, 1'b0);
    play_step(100, 2, 0, 0, 1'b1);
    play_step(0, 1, 1, 100, 1'b0);
    play_step(300, 2, 2, 0, 1'b0);
    check_done();

    // Asynchronous reset mid-PLAY
    start_seq(3, 1'b0);
    cyc();
    chk("pre_rst_pulse", 32'(step_pulse_out), 32'd1);
    #2 rst_in = 1'b1;
    #1;
    chk("arst_period", period_out, 32'd0);
    chk("arst_active", 32'(active_out), 32'd0);
    chk("arst_busy", 32'(busy_out), 32'd0);
    chk("arst_step", 32'(step_out), 32'd0);
    chk("arst_pulse", 32'(step_pulse_out), 32'd0);
    chk("arst_done", 32'(done_out), 32'd0);
    cyc();
    rst_in = 1'b0;
    start_seq(3, 1'b0);
    play_step(100, 2, 0, 0, 1'b0);
    play_step(0, 1, 1, 100, 1'b0);
    play_step(300, 2, 2, 0, 1'b0);
    check_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
